vga_sync_monitor: RTL and testbench
===================================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 The parameter H_TOTAL SHALL default to 3200 and set the expected clocks per line (800 pixels x 4 clocks).
REQ-002 The parameter H_SYNC SHALL default to 384 and set the expected hsync low width in clocks.
REQ-003 The parameter V_TOTAL SHALL default to 525 and set the expected lines per frame.
REQ-004 The parameter V_SYNC SHALL default to 2 and set the expected vsync low width in lines.
REQ-005 Ports SHALL be `clock` (input, 1, sole clock, rising edge) and `reset_n` (input, 1, synchronous active-low reset).
REQ-006 Ports SHALL be `hsync` and `vsync` (input, 1 each, active-low syncs from the VGA generator).
REQ-007 Ports SHALL be `blanking` (input, 1, 1 = blanked) and `colores` (input, 8, pixel colour).
REQ-008 Port `clr_err` SHALL be an input of width 1 that clears the sticky error bits.
REQ-009 Port `locked` SHALL be an output of width 1 that is high while timing is verified.
REQ-010 Port `err_sticky` SHALL be an output of width 4, with bits {vwidth, vperiod, hwidth, hperiod}.
REQ-011 Port `err_pulse` SHALL be an output of width 4, giving a one-cycle strobe per error, in the same bit order as `err_sticky`.
REQ-012 Port `frame_count` SHALL be an output of width 16 that counts good frames while locked.
REQ-013 Port `frame_sum` SHALL be an output of width 16 holding the checksum of the last frame.

Function
REQ-014 `hsync` and `vsync` SHALL be registered once; a falling or rising edge SHALL be detected by comparing each input with its registered copy.
REQ-015 The block SHALL measure the h-period as the clocks between consecutive hsync falling edges, using a 12-bit counter that saturates at 4095.
REQ-016 The block SHALL measure the h-width as the clocks from an hsync falling edge to the next hsync rising edge.
REQ-017 The block SHALL measure the v-period as the count of hsync falling edges between consecutive vsync falling edges, using a 10-bit counter that saturates at 1023.
REQ-018 The block SHALL measure the v-width as the count of hsync falling edges seen while vsync is low.
REQ-019 Each measurement SHALL be compared at its closing edge; on a mismatch, the matching `err_pulse` bit SHALL assert for exactly one cycle, one clock after the closing edge is sampled.
REQ-020 A comparison SHALL be made only if its opening edge has been seen since reset or since entering SEARCH; no error SHALL be raised on partial first measurements.
REQ-021 An `err_sticky` bit SHALL be set by its pulse and cleared by `clr_err`; if the two coincide, the set SHALL win.
REQ-022 The state machine SHALL have three states: SEARCH, ACQUIRE and LOCKED.
REQ-023 SEARCH SHALL move to ACQUIRE on the first vsync falling edge.
REQ-024 ACQUIRE SHALL move to LOCKED at the next vsync falling edge if no error pulse occurred since entering ACQUIRE; otherwise it SHALL stay in ACQUIRE and restart the frame.
REQ-025 LOCKED SHALL move to SEARCH on any error pulse; `locked` SHALL drop in the same cycle as the pulse.
REQ-026 `locked` SHALL equal (state == LOCKED), registered.
REQ-027 `frame_count` SHALL increment by 1 at each vsync falling edge while LOCKED, and SHALL wrap from 0xFFFF to 0.
REQ-028 `frame_count` SHALL hold its value, not clear, when the state leaves LOCKED.
REQ-029 If an error pulse and a vsync falling edge coincide while LOCKED, the error SHALL win: no increment, and the state SHALL go to SEARCH.

Reset
REQ-030 While `reset_n` = 0 at a rising edge, all counters, the edge registers, `err_sticky`, `err_pulse`, `frame_count` and `frame_sum` SHALL become 0, `locked` SHALL become 0, and the state SHALL become SEARCH.
REQ-031 A reset asserted mid-frame SHALL discard all partial measurements; the first post-reset edges SHALL only open measurements.

Configuration
REQ-032 With VGA_MON_CHECKSUM_EN defined, an accumulator SHALL add `colores` modulo 2^16 on every clock where `blanking` = 0.
REQ-033 With VGA_MON_CHECKSUM_EN defined, at each vsync falling edge the accumulator value SHALL be copied to `frame_sum` and the accumulator SHALL restart from 0, plus the current pixel if that pixel is unblanked.
REQ-034 Without VGA_MON_CHECKSUM_EN, `frame_sum` SHALL be constant 0 and no accumulator logic SHALL be present.

Structure
REQ-035 The default timing constants, the state encodings and the `err` bit indices SHALL live in a shared package/include, `vga_mon_pkg`, reused by the VGA generator and the benches.
REQ-036 A sub-module, `vga_edge_det`, SHALL provide the register plus rise/fall strobes and SHALL be instantiated once for hsync and once for vsync.

Verification
REQ-037 Nominal 640x480 timing at 4 clocks per pixel -> `locked` SHALL rise at the 2nd vsync falling edge, with no `err_pulse` and `frame_count` = 3 after 5 frames.
REQ-038 After lock, one line of 3199 clocks -> `err_pulse[0]` SHALL be 1 for one cycle, `locked` SHALL be 0 in the same cycle, and `err_sticky` SHALL be 4'b0001.
REQ-039 After lock, hsync low for 380 clocks -> `err_pulse[1]` SHALL pulse, the state SHALL be SEARCH, and lock SHALL be regained 2 frames later.
REQ-040 `clr_err` asserted in the same cycle as a vperiod error, with a frame of 524 lines -> `err_sticky[2]` SHALL remain 1.
REQ-041 `reset_n` = 0 for 3 cycles at line 200 -> all outputs SHALL be 0, no error SHALL occur on the partial line or frame, and `locked` SHALL rise 2 vsync edges later.
REQ-042 With VGA_MON_CHECKSUM_EN defined, `colores` = 8'h01 over 640x480x4 unblanked clocks -> `frame_sum` SHALL be 16'hC000.

Source files
------------

// File: rtl/vga_mon_pkg.sv
// rtl/vga_mon_pkg.sv - shared VGA timing defaults, monitor state encoding and error bit indices
package vga_mon_pkg;

    localparam int H_TOTAL_DEF = 3200;
    localparam int H_SYNC_DEF  = 384;
    localparam int V_TOTAL_DEF = 525;
    localparam int V_SYNC_DEF  = 2;

    localparam int HCNT_W = 12;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    localparam int ERR_HPERIOD = 0;
    localparam int ERR_HWIDTH  = 1;
    localparam int ERR_VPERIOD = 2;
    localparam int ERR_VWIDTH  = 3;

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - single-register edge detector with combinational rise/fall strobes
module vga_edge_det (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_sig;
        end
    end

    assign o_rise = ~r_q & i_sig;
    assign o_fall = r_q & ~i_sig;

endmodule

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - checks hsync/vsync period and width, tracks lock and counts good frames
// Optional VGA_MON_CHECKSUM_EN adds a per-frame sum of unblanked pixel colours on frame_sum.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int V_SYNC  = V_SYNC_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blanking,
    input  logic [7:0]  colores,
    input  logic        clr_err,
    output logic        locked,
    output logic [3:0]  err_sticky,
    output logic [3:0]  err_pulse,
    output logic [15:0] frame_count,
    output logic [15:0] frame_sum
);

    localparam logic [HCNT_W-1:0] C_HTOT  = HCNT_W'(H_TOTAL);
    localparam logic [HCNT_W-1:0] C_HSYNC = HCNT_W'(H_SYNC);
    localparam logic [VCNT_W-1:0] C_VTOT  = VCNT_W'(V_TOTAL);
    localparam logic [VCNT_W-1:0] C_VSYNC = VCNT_W'(V_SYNC);

    logic w_hrise, w_hfall, w_vrise, w_vfall;
    logic [3:0] w_err;
    logic w_any_err, w_to_search;

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic r_hopen, r_vopen;
    logic [3:0] r_err_pulse, r_err_sticky;
    mon_state_t r_state;
    logic r_locked, r_acq_err;
    logic [15:0] r_frame_count;

    vga_edge_det u_hs_edge (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_sig     (hsync),
        .o_rise    (w_hrise),
        .o_fall    (w_hfall)
    );

    vga_edge_det u_vs_edge (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_sig     (vsync),
        .o_rise    (w_vrise),
        .o_fall    (w_vfall)
    );

    // One counter per axis serves both period and width: width is read at the rising edge.
    always_comb begin
        w_err = '0;
        w_err[ERR_HPERIOD] = w_hfall & r_hopen & (r_hcnt != C_HTOT);
        w_err[ERR_HWIDTH]  = w_hrise & r_hopen & (r_hcnt != C_HSYNC);
        w_err[ERR_VPERIOD] = w_vfall & r_vopen & (r_vcnt != C_VTOT);
        w_err[ERR_VWIDTH]  = w_vrise & r_vopen & (r_vcnt != C_VSYNC);
    end

    assign w_any_err   = |w_err;
    assign w_to_search = (r_state == ST_LOCKED) & w_any_err;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_hopen      <= 1'b0;
            r_vopen      <= 1'b0;
            r_err_pulse  <= '0;
            r_err_sticky <= '0;
        end else begin
            if (w_hfall) begin
                r_hcnt <= HCNT_W'(1);
            end else if (r_hcnt != '1) begin
                r_hcnt <= r_hcnt + HCNT_W'(1);
            end
            if (w_vfall) begin
                r_vcnt <= {{(VCNT_W-1){1'b0}}, w_hfall};
            end else if (w_hfall && (r_vcnt != '1)) begin
                r_vcnt <= r_vcnt + VCNT_W'(1);
            end
            // Falling back to SEARCH forgets open measurements, except one opened right now.
            r_hopen      <= (r_hopen & ~w_to_search) | w_hfall;
            r_vopen      <= (r_vopen & ~w_to_search) | w_vfall;
            r_err_pulse  <= w_err;
            r_err_sticky <= (clr_err ? 4'b0000 : r_err_sticky) | w_err;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_SEARCH;
            r_locked      <= 1'b0;
            r_acq_err     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_vfall) begin
                        r_state   <= ST_ACQUIRE;
                        r_acq_err <= 1'b0;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_vfall) begin
                        if (!r_acq_err && !w_any_err) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                        r_acq_err <= 1'b0;
                    end else if (w_any_err) begin
                        r_acq_err <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_any_err) begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                    end else if (w_vfall) begin
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked      = r_locked;
    assign err_pulse   = r_err_pulse;
    assign err_sticky  = r_err_sticky;
    assign frame_count = r_frame_count;

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] r_acc, r_frame_sum;
    logic [15:0] w_pix;

    assign w_pix = blanking ? 16'd0 : {8'd0, colores};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_frame_sum <= '0;
        end else if (w_vfall) begin
            r_frame_sum <= r_acc;
            r_acc       <= w_pix;
        end else begin
            r_acc <= r_acc + w_pix;
        end
    end

    assign frame_sum = r_frame_sum;
`else
    logic w_unused_pix;
    assign w_unused_pix = ^{blanking, colores};
    assign frame_sum    = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - directed bench for vga_sync_monitor on a scaled-down raster
module tb_vga_sync_monitor;

    localparam int HT = 40;
    localparam int HS = 6;
    localparam int VT = 12;
    localparam int VS = 2;

`ifdef VGA_MON_CHECKSUM_EN
    localparam logic [15:0] SUM_FULL = 16'h0100;
    localparam logic [15:0] SUM_PART = 16'h007B;
`else
    localparam logic [15:0] SUM_FULL = 16'h0000;
    localparam logic [15:0] SUM_PART = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        hsync, vsync, blanking, clr_err;
    logic [7:0]  colores;
    logic        locked;
    logic [3:0]  err_sticky, err_pulse;
    logic [15:0] frame_count, frame_sum;

    int checks = 0;
    int errors = 0;

    logic [3:0]  pulse_or;
    int          pulse_cycles;
    logic        lock_at_pulse;
    logic [3:0]  sticky_at_pulse;
    logic        lock_at_start;
    logic [40:0] rst_snap;

    vga_sync_monitor #(
        .H_TOTAL (HT),
        .H_SYNC  (HS),
        .V_TOTAL (VT),
        .V_SYNC  (VS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .blanking    (blanking),
        .colores     (colores),
        .clr_err     (clr_err),
        .locked      (locked),
        .err_sticky  (err_sticky),
        .err_pulse   (err_pulse),
        .frame_count (frame_count),
        .frame_sum   (frame_sum)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        pulse_or        = 4'b0000;
        pulse_cycles    = 0;
        lock_at_pulse   = 1'bx;
        sticky_at_pulse = 4'bxxxx;
    endtask

    task automatic run_line(input int l, input int len, input int sw, input bit do_clr, input bit do_rst);
        for (int c = 0; c < len; c++) begin
            hsync    = (c >= sw);
            vsync    = (l >= VS);
            blanking = (l >= 2 && l < 10 && c >= 8) ? 1'b0 : 1'b1;
            colores  = 8'h01;
            clr_err  = do_clr && (c == 0);
            reset_n  = !(do_rst && c >= 10 && c < 13);
            @(posedge clock);
            #1;
            if (err_pulse !== 4'b0000) begin
                pulse_or = pulse_or | err_pulse;
                pulse_cycles++;
                if (pulse_cycles == 1) begin
                    lock_at_pulse   = locked;
                    sticky_at_pulse = err_sticky;
                end
            end
            if (l == 0 && c == 0) lock_at_start = locked;
            if (do_rst && c == 12) rst_snap = {locked, err_sticky, err_pulse, frame_count, frame_sum};
        end
        clr_err = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int lines, input int bad_line, input int bad_len, input int bad_sw,
                             input int clr_line, input int rst_line);
        for (int l = 0; l < lines; l++) begin
            run_line(l, (l == bad_line) ? bad_len : HT, (l == bad_line) ? bad_sw : HS,
                     l == clr_line, l == rst_line);
        end
    endtask

    task automatic good_frame();
        run_frame(VT, -1, HT, HS, -1, -1);
    endtask

    initial begin
        reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; blanking = 1'b1; colores = 8'h00; clr_err = 1'b0;
        clear_obs();
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {locked, err_sticky, err_pulse, frame_count, frame_sum}, 41'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Nominal timing: lock at the second vsync fall, three counted frames after five.
        good_frame();
        check("lock_at_vfall1", lock_at_start, 1'b0);
        good_frame();
        check("lock_at_vfall2", lock_at_start, 1'b1);
        good_frame(); good_frame(); good_frame();
        check("nominal_no_pulse", pulse_or, 4'b0000);
        check("nominal_frame_count", frame_count, 16'd3);
        check("nominal_locked", locked, 1'b1);
        check("nominal_sticky", err_sticky, 4'b0000);
        check("nominal_frame_sum", frame_sum, SUM_FULL);

        // One short line.
        clear_obs();
        run_frame(VT, 3, HT - 1, HS, -1, -1);
        check("hper_pulse", pulse_or, 4'b0001);
        check("hper_pulse_len", pulse_cycles, 1);
        check("hper_lock_at_pulse", lock_at_pulse, 1'b0);
        check("hper_sticky_at_pulse", sticky_at_pulse, 4'b0001);
        check("hper_locked_after", locked, 1'b0);
        check("hper_frame_count", frame_count, 16'd4);

        clear_obs();
        good_frame();
        check("hper_relock_vf1", lock_at_start, 1'b0);
        good_frame();
        check("hper_relock_vf2", lock_at_start, 1'b1);
        check("hper_relock_no_pulse", pulse_or, 4'b0000);

        // Narrow hsync.
        clear_obs();
        run_frame(VT, 5, HT, HS - 1, -1, -1);
        check("hwid_pulse", pulse_or, 4'b0010);
        check("hwid_lock_at_pulse", lock_at_pulse, 1'b0);
        check("hwid_sticky", err_sticky, 4'b0011);
        check("hwid_locked_after", locked, 1'b0);
        good_frame();
        check("hwid_search_vf1", lock_at_start, 1'b0);
        good_frame();
        check("hwid_relock_vf2", lock_at_start, 1'b1);
        check("hwid_frame_count", frame_count, 16'd5);

        // Short frame, with clr_err coinciding with the vperiod error.
        clear_obs();
        run_frame(VT - 1, -1, HT, HS, -1, -1);
        run_frame(VT, -1, HT, HS, 0, -1);
        check("vper_pulse", pulse_or, 4'b0100);
        check("vper_pulse_len", pulse_cycles, 1);
        check("vper_sticky_set_wins", sticky_at_pulse, 4'b0100);
        check("vper_frame_count", frame_count, 16'd6);

        // Reset mid-frame while locked.
        good_frame();
        good_frame();
        check("pre_reset_locked", lock_at_start, 1'b1);
        clear_obs();
        run_frame(VT, -1, HT, HS, -1, 6);
        check("reset_midframe_outputs", rst_snap, 41'd0);
        good_frame();
        check("post_reset_vf1", lock_at_start, 1'b0);
        check("post_reset_partial_sum", frame_sum, SUM_PART);
        good_frame();
        check("post_reset_vf2", lock_at_start, 1'b1);
        check("post_reset_full_sum", frame_sum, SUM_FULL);
        good_frame();
        check("post_reset_no_pulse", pulse_or, 4'b0000);
        check("post_reset_frame_count", frame_count, 16'd1);
        check("post_reset_sticky", err_sticky, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
